// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one ALU between two valid/ready requesters
// and sequences a 16-step shift-add multiply through the ALU ADD path.
module alu_arbiter #(
  parameter logic [2:0] MUL_OP = 3'b111,
  parameter int         WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,

  output logic             busy
);

  localparam int STEP_W = $clog2(WIDTH);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_next;

  logic              last_grant;
  logic              grant_id;
  logic              sel;
  logic              accept;
  logic              rsp_take;
  logic [WIDTH-1:0]  cap_a;
  logic [WIDTH-1:0]  cap_b;
  logic [2:0]        cap_op;
  logic [WIDTH-1:0]  acc;
  logic [STEP_W-1:0] step;
  logic              mul_last;
  logic [WIDTH-1:0]  acc_next;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [2:0]        sel_op;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    if (req0_valid && req1_valid) begin
      sel = ~last_grant;
    end else begin
      sel = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !sel;
  assign req1_ready = (state == IDLE) && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;

  assign sel_a  = sel ? req1_a  : req0_a;
  assign sel_b  = sel ? req1_b  : req0_b;
  assign sel_op = sel ? req1_op : req0_op;

  assign rsp_take = (state == RESP) && (grant_id ? rsp1_ready : rsp0_ready);

  assign mul_last = (step == LAST_STEP);
  assign acc_next = cap_b[step] ? alu_result : acc;

  assign rsp0_valid = (state == RESP) && !grant_id;
  assign rsp1_valid = (state == RESP) && grant_id;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (sel_op == MUL_OP) ? MUL : EXEC;
        end
      end
      EXEC: state_next = RESP;
      MUL: begin
        if (mul_last) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_take) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Multiply step i adds (a << i) to the accumulator through the ALU ADD path.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 3'b000;
    case (state)
      EXEC: begin
        alu_a  = cap_a;
        alu_b  = cap_b;
        alu_op = cap_op;
      end
      MUL: begin
        alu_a  = acc;
        alu_b  = cap_a << step;
        alu_op = 3'b000;
      end
      default: begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      cap_a       <= '0;
      cap_b       <= '0;
      cap_op      <= 3'b000;
      acc         <= '0;
      step        <= '0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_a      <= sel_a;
            cap_b      <= sel_b;
            cap_op     <= sel_op;
            grant_id   <= sel;
            last_grant <= sel;
            acc        <= '0;
            step       <= '0;
          end
        end
        EXEC: begin
          if (grant_id) begin
            rsp1_result <= alu_result;
            rsp1_zero   <= alu_zero;
          end else begin
            rsp0_result <= alu_result;
            rsp0_zero   <= alu_zero;
          end
        end
        MUL: begin
          acc  <= acc_next;
          step <= step + 1'b1;
          if (mul_last) begin
            if (grant_id) begin
              rsp1_result <= acc_next;
              rsp1_zero   <= (acc_next == '0);
            end else begin
              rsp0_result <= acc_next;
              rsp0_zero   <= (acc_next == '0);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU drives the DUT's ALU port,
// accepted commands queue expected responses that a negedge monitor checks.
module tb_alu_arbiter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]       req0_op = '0, req1_op = '0;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic             rsp0_zero, rsp1_zero;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_op;
  logic             alu_zero;
  logic             busy;

  alu_arbiter #(.MUL_OP(3'b111), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, others return 0.
  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_a, alu_b, alu_op);
    alu_zero   = (alu_result == '0);
  end

  function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                   input logic [2:0] op);
    logic [31:0] prod;
    if (op == 3'b111) begin
      prod = 32'(a) * 32'(b);
      return prod[WIDTH-1:0];
    end
    return alu_fn(a, b, op);
  endfunction

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    int               cyc;
    int               lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  bit   seen0, seen1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rsp_mode = 1;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic exp_t make_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic [2:0] op);
    exp_t e;
    e.res  = ref_result(a, b, op);
    e.zero = (e.res == '0);
    e.cyc  = cyc;
    e.lat  = (op == 3'b111) ? 17 : 2;
    return e;
  endfunction

  task automatic monitor_rsp(input int id, input logic v, input logic r,
                             input logic [WIDTH-1:0] res, input logic z);
    exp_t e;
    int   qsize;
    if (!v) return;
    qsize = (id == 0) ? q0.size() : q1.size();
    if (qsize == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unexpected_rsp%0d: got valid with result 0x%0h, required no response", id, res);
      return;
    end
    e = (id == 0) ? q0[0] : q1[0];
    if (id == 0 && !seen0) begin
      seen0 = 1'b1;
      checkOutput("latency0", cyc - e.cyc, e.lat);
    end
    if (id == 1 && !seen1) begin
      seen1 = 1'b1;
      checkOutput("latency1", cyc - e.cyc, e.lat);
    end
    checkOutput($sformatf("rsp%0d_result", id), res, e.res);
    checkOutput($sformatf("rsp%0d_zero", id), z, e.zero);
    if (r) begin
      if (id == 0) begin
        void'(q0.pop_front());
        seen0 = 1'b0;
      end else begin
        void'(q1.pop_front());
        seen1 = 1'b0;
      end
    end
  endtask

  // Monitor samples mid-cycle; handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      seen0 = 1'b0;
      seen1 = 1'b0;
    end else begin
      if (req0_ready || req1_ready) checkOutput("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (rsp0_valid || rsp1_valid) checkOutput("rsp_valid_exclusive", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
      if (req0_valid && req0_ready) begin
        q0.push_back(make_exp(req0_a, req0_b, req0_op));
        grant_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        q1.push_back(make_exp(req1_a, req1_b, req1_op));
        grant_log.push_back(1);
      end
      monitor_rsp(0, rsp0_valid, rsp0_ready, rsp0_result, rsp0_zero);
      monitor_rsp(1, rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rsp_mode == 1) begin
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
    end else if (rsp_mode == 2) begin
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic applyStimulus(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [2:0] op, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    @(posedge clk);
    #1;
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout%0d: got no ready in 400 cycles, required ready", id);
    end
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic check_quiet(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
    checkOutput({tag, "_rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
    checkOutput({tag, "_alu_a"}, {16'd0, alu_a}, 32'd0);
    checkOutput({tag, "_alu_b"}, {16'd0, alu_b}, 32'd0);
    checkOutput({tag, "_alu_op"}, {29'd0, alu_op}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic random_traffic(input int id, input int count);
    int w;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      applyStimulus(id, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), w);
    end
  endtask

  initial begin
    int w;
    rsp_mode = 1;
    rst_n = 1'b0;
    #12;
    check_quiet("reset");
    checkOutput("reset_rsp0_result", {16'd0, rsp0_result}, 32'd0);
    checkOutput("reset_rsp1_result", {16'd0, rsp1_result}, 32'd0);
    checkOutput("reset_rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
    checkOutput("reset_rsp1_zero", {31'd0, rsp1_zero}, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    applyStimulus(0, 16'd5, 16'd3, 3'b000, w);
    checkOutput("first_accept_wait", w, 0);
    wait_drain();
    applyStimulus(1, 16'd7, 16'd7, 3'b001, w);
    wait_drain();

    do_reset();
    grant_log.delete();
    fork
      for (int i = 0; i < 3; i++) begin
        int w0;
        applyStimulus(0, 16'd1, 16'd1, 3'b000, w0);
      end
      for (int i = 0; i < 3; i++) begin
        int w1;
        applyStimulus(1, 16'hFF00, 16'h0FF0, 3'b010, w1);
      end
    join
    wait_drain();
    checkOutput("grant_count", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size(); i++) checkOutput($sformatf("grant_order%0d", i), grant_log[i], i % 2);

    applyStimulus(0, 16'd300, 16'd250, 3'b111, w);
    wait_drain();
    applyStimulus(0, 16'h0100, 16'h0100, 3'b111, w);
    wait_drain();

    rsp_mode = 0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    applyStimulus(0, 16'd10, 16'd20, 3'b000, w);
    for (int i = 0; i < 20 && !rsp0_valid; i++) @(negedge clk);
    checkOutput("bp_rsp0_seen", {31'd0, rsp0_valid}, 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b1; req1_a = 16'd9; req1_b = 16'd4; req1_op = 3'b001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
      checkOutput("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("bp_req1_ready_after", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    rsp_mode = 1;
    wait_drain();

    applyStimulus(0, 16'd300, 16'd250, 3'b111, w);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("mulreset");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(0, 16'd2, 16'd2, 3'b000, w);
    wait_drain();

    rsp_mode = 2;
    fork
      random_traffic(0, 30);
      random_traffic(1, 30);
    join
    rsp_mode = 1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
